// File: rtl/jtag_ir_dr_path.sv
// JTAG IR/DR path behind the TAP controller: IR, BYPASS, USER DR and optional IDCODE DR (JTAG_IDCODE_EN).
// Registers update on posedge TCK; TDO/TDO_EN follow half a cycle later on negedge TCK.
module jtag_ir_dr_path #(
  parameter int          IR_WIDTH   = 4,
  parameter int          USER_WIDTH = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                  TCK,
  input  logic                  TRST,
  input  logic                  TDI,
  input  logic [3:0]            state,
  input  logic [USER_WIDTH-1:0] user_dr_in,
  output logic                  TDO,
  output logic                  TDO_EN,
  output logic [IR_WIDTH-1:0]   ir_out,
  output logic [USER_WIDTH-1:0] user_dr_out
);

  typedef enum logic [3:0] {
    TLR      = 4'h0, RTI      = 4'h1, SEL_DR   = 4'h2, CAP_DR   = 4'h3,
    SH_DR    = 4'h4, EX1_DR   = 4'h5, PAUSE_DR = 4'h6, EX2_DR   = 4'h7,
    UPD_DR   = 4'h8, SEL_IR   = 4'h9, CAP_IR   = 4'hA, SH_IR    = 4'hB,
    EX1_IR   = 4'hC, PAUSE_IR = 4'hD, EX2_IR   = 4'hE, UPD_IR   = 4'hF
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RST_INSTR = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RST_INSTR = OP_BYPASS;
`endif

  tap_state_t            st;
  logic [IR_WIDTH-1:0]   ir_shift;
  logic                  bypass;
  logic [USER_WIDTH-1:0] user_shift;
  logic                  sel_user;
  logic                  sel_id;
  logic                  sel_bypass;
  logic                  dr_lsb;

  assign st       = tap_state_t'(state);
  assign sel_user = (ir_out == OP_USER);
`ifdef JTAG_IDCODE_EN
  assign sel_id   = (ir_out == OP_IDCODE);
`else
  assign sel_id   = 1'b0;
`endif
  // Every opcode that is not a recognised DR falls back to the 1-bit bypass path.
  assign sel_bypass = !sel_user && !sel_id;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_out      <= RST_INSTR;
      ir_shift    <= '0;
      bypass      <= 1'b0;
      user_shift  <= '0;
      user_dr_out <= '0;
    end else begin
      case (st)
        TLR:    ir_out   <= RST_INSTR;
        CAP_IR: ir_shift <= IR_WIDTH'(2'b01);
        SH_IR:  ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        UPD_IR: ir_out   <= ir_shift;
        CAP_DR: begin
          if (sel_user)   user_shift <= user_dr_in;
          if (sel_bypass) bypass     <= 1'b0;
        end
        SH_DR: begin
          // Shift form that stays legal for a 1-bit USER register.
          if (sel_user)   user_shift <= (user_shift >> 1) | (USER_WIDTH'(TDI) << (USER_WIDTH - 1));
          if (sel_bypass) bypass     <= TDI;
        end
        UPD_DR: if (sel_user) user_dr_out <= user_shift;
        default: ;
      endcase
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] id_shift;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      id_shift <= '0;
    end else if (sel_id) begin
      if (st == CAP_DR)     id_shift <= IDCODE_VAL;
      else if (st == SH_DR) id_shift <= {TDI, id_shift[31:1]};
    end
  end
`endif

  always_comb begin
    dr_lsb = bypass;
`ifdef JTAG_IDCODE_EN
    if (sel_id) dr_lsb = id_shift[0];
`endif
    if (sel_user) dr_lsb = user_shift[0];
  end

  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else if (st == SH_IR) begin
      TDO    <= ir_shift[0];
      TDO_EN <= 1'b1;
    end else if (st == SH_DR) begin
      TDO    <= dr_lsb;
      TDO_EN <= 1'b1;
    end else begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_ir_dr_path.sv
// Directed bench for jtag_ir_dr_path: expected TDO bits are queued as stimulus is planned and
// popped on each shift cycle; register outputs are checked at directed points.
module tb_jtag_ir_dr_path;

  localparam logic [3:0] S_TLR = 4'h0, S_RTI = 4'h1, S_CAP_DR = 4'h3, S_SH_DR = 4'h4,
                         S_EX1_DR = 4'h5, S_UPD_DR = 4'h8, S_CAP_IR = 4'hA, S_SH_IR = 4'hB,
                         S_EX1_IR = 4'hC, S_UPD_IR = 4'hF;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] RST_INSTR = 4'h1;
`else
  localparam logic [3:0] RST_INSTR = 4'hF;
`endif

  logic       TCK = 1'b0;
  logic       TRST;
  logic       TDI;
  logic [3:0] state;
  logic [7:0] user_dr_in;
  logic       TDO;
  logic       TDO_EN;
  logic [3:0] ir_out;
  logic [7:0] user_dr_out;

  int   tests = 0;
  int   fails = 0;
  logic exp_q[$];

  jtag_ir_dr_path #(.IR_WIDTH(4), .USER_WIDTH(8), .IDCODE_VAL(32'h1000_0001)) dut (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .state(state), .user_dr_in(user_dr_in),
    .TDO(TDO), .TDO_EN(TDO_EN), .ir_out(ir_out), .user_dr_out(user_dr_out)
  );

  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One TCK cycle: drive before negedge, check TDO after negedge, return just after posedge.
  task automatic step(input logic [3:0] s, input logic tdi);
    logic shifting;
    logic e;
    state = s;
    TDI   = tdi;
    @(negedge TCK);
    #1;
    shifting = (s == S_SH_IR) || (s == S_SH_DR);
    chk("tdo_en", {31'b0, TDO_EN}, {31'b0, shifting});
    if (shifting) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_empty observed=%b expected=queued_bit", TDO);
      end else begin
        e = exp_q.pop_front();
        chk("tdo", {31'b0, TDO}, {31'b0, e});
      end
    end else begin
      chk("tdo_idle", {31'b0, TDO}, 32'd0);
    end
    @(posedge TCK);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] v);
    step(S_CAP_IR, 1'b0);
    exp_q.push_back(1'b1);
    for (int i = 1; i < 4; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) step(S_SH_IR, v[i]);
    step(S_EX1_IR, 1'b0);
    step(S_UPD_IR, 1'b0);
    chk("ir_out_load", {28'b0, ir_out}, {28'b0, v});
    step(S_RTI, 1'b0);
  endtask

  task automatic bypass_scan();
    logic [2:0] pat;
    pat = 3'b101;
    step(S_CAP_DR, 1'b0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int i = 2; i >= 0; i--) step(S_SH_DR, pat[i]);
    step(S_EX1_DR, 1'b0);
    step(S_UPD_DR, 1'b0);
    step(S_RTI, 1'b0);
  endtask

  initial begin
    logic [31:0] idv;
    logic [7:0]  uv;
    logic [7:0]  wv;
    logic        b;
    logic        prev;
    idv = 32'h1000_0001;
    TRST = 1'b1;
    TDI = 1'b0;
    state = S_TLR;
    user_dr_in = 8'h00;
    #12;
    TRST = 1'b0;
    chk("rst_tdo", {31'b0, TDO}, 32'd0);
    chk("rst_tdo_en", {31'b0, TDO_EN}, 32'd0);
    chk("rst_user_dr_out", {24'b0, user_dr_out}, 32'd0);
    chk("rst_ir_out", {28'b0, ir_out}, {28'b0, RST_INSTR});

    // DR scan straight after reset: IDCODE when present, else the bypass delay line.
    step(S_CAP_DR, 1'b0);
    prev = 1'b0;
    for (int i = 0; i < 32; i++) begin
      b = 1'($urandom_range(0, 1));
`ifdef JTAG_IDCODE_EN
      exp_q.push_back(idv[i]);
`else
      exp_q.push_back(prev);
`endif
      prev = b;
      step(S_SH_DR, b);
    end
    step(S_EX1_DR, 1'b0);
    step(S_UPD_DR, 1'b0);
    step(S_RTI, 1'b0);

    // IR capture pattern and USER load (TDI 0,1,0,0).
    load_ir(4'h2);

    // USER write/read.
    uv = 8'hA5;
    wv = 8'h3C;
    user_dr_in = uv;
    step(S_CAP_DR, 1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(uv[i]);
    for (int i = 0; i < 8; i++) step(S_SH_DR, wv[i]);
    step(S_EX1_DR, 1'b0);
    chk("user_no_early_update", {24'b0, user_dr_out}, 32'd0);
    step(S_UPD_DR, 1'b0);
    chk("user_dr_out", {24'b0, user_dr_out}, 32'h3C);
    chk("ir_stable_dr", {28'b0, ir_out}, 32'h2);
    step(S_RTI, 1'b0);

    // BYPASS, then an undefined opcode which must behave the same.
    load_ir(4'hF);
    bypass_scan();
    chk("user_untouched_bypass", {24'b0, user_dr_out}, 32'h3C);
    load_ir(4'h5);
    bypass_scan();
    chk("user_untouched_undef", {24'b0, user_dr_out}, 32'h3C);

    // TLR forces the reset instruction without disturbing the USER latch.
    load_ir(4'h2);
    step(S_TLR, 1'b0);
    chk("tlr_ir_out", {28'b0, ir_out}, {28'b0, RST_INSTR});
    chk("tlr_user_keep", {24'b0, user_dr_out}, 32'h3C);
    step(S_RTI, 1'b0);

    // TRST in the middle of a USER shift.
    load_ir(4'h2);
    uv = 8'h5A;
    user_dr_in = uv;
    step(S_CAP_DR, 1'b0);
    for (int i = 0; i < 3; i++) exp_q.push_back(uv[i]);
    for (int i = 0; i < 3; i++) step(S_SH_DR, 1'b1);
    TRST = 1'b1;
    #2;
    chk("trst_tdo", {31'b0, TDO}, 32'd0);
    chk("trst_tdo_en", {31'b0, TDO_EN}, 32'd0);
    chk("trst_user_dr_out", {24'b0, user_dr_out}, 32'd0);
    chk("trst_ir_out", {28'b0, ir_out}, {28'b0, RST_INSTR});
    TRST = 1'b0;
    state = S_RTI;
    step(S_RTI, 1'b0);
    chk("post_trst_ir_out", {28'b0, ir_out}, {28'b0, RST_INSTR});

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
